// File: rtl/m31_poseidon2_sponge_ctrl_if.sv
// Host-facing word stream and digest return channel of the Poseidon2 sponge controller.
// The master side is the host; the slave side is the controller.
interface m31_poseidon2_sponge_ctrl_if #(
  parameter int DIGEST = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [30:0]           in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIGEST*31-1:0]  out_data;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/m31_poseidon2_sponge_ctrl.sv
// Sponge controller for a fixed-latency Poseidon2 core over M31: absorbs message words into
// the rate lanes, launches one permutation per block and returns the digest lanes.
module m31_poseidon2_sponge_ctrl #(
  parameter int WIDTH        = 16,
  parameter int RATE         = 8,
  parameter int DIGEST       = 8,
  parameter int PERM_LATENCY = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  m31_poseidon2_sponge_ctrl_if.slave bus,
  output logic [WIDTH*31-1:0]   perm_state_o,
  input  logic [WIDTH*31-1:0]   perm_state_i,
  output logic                  busy
);

  localparam logic [1:0] ST_ABSORB = 2'd0;
  localparam logic [1:0] ST_PERM   = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  localparam int          IDX_W = (RATE > 1) ? $clog2(RATE + 1) : 1;
  localparam int          CNT_W = $clog2(PERM_LATENCY + 1) + 1;
  localparam logic [30:0] P_M31 = 31'h7FFF_FFFF;

  function automatic logic [30:0] add_mod(input logic [30:0] a, input logic [30:0] b);
    logic [31:0] s;
    logic [30:0] f;
    s = {1'b0, a} + {1'b0, b};
    f = s[30:0] + {30'd0, s[31]};
    return (f == P_M31) ? 31'd0 : f;
  endfunction

  function automatic logic [30:0] reduce_m31(input logic [30:0] w);
    return (w == P_M31) ? 31'd0 : w;
  endfunction

  logic [1:0]                r_fsm;
  logic [WIDTH-1:0][30:0]    r_lane;
  logic [WIDTH-1:0][30:0]    r_perm_o;
  logic [IDX_W-1:0]          r_idx;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_final;
  logic                      r_out_valid;
  logic [DIGEST*31-1:0]      r_out_data;

  logic [WIDTH-1:0][30:0]    w_upd;
  logic [30:0]               w_word;
  logic [30:0]               w_count;
  logic                      w_in_ready;
  logic                      w_hs;
  logic                      w_blk_done;
  logic                      w_capture;

  assign w_in_ready = rst_n && (r_fsm == ST_ABSORB);
  assign w_hs       = bus.in_valid && w_in_ready;
  assign w_blk_done = bus.in_last || (r_idx == IDX_W'(RATE - 1));
  assign w_capture  = (r_cnt == CNT_W'(PERM_LATENCY));
  assign w_word     = reduce_m31(bus.in_data);
  assign w_count    = 31'(r_idx) + 31'd1;

  // Next state if the current word is accepted; the final block also absorbs its word count
  always_comb begin
    w_upd        = r_lane;
    w_upd[r_idx] = add_mod(r_lane[r_idx], w_word);
    if (bus.in_last) begin
      w_upd[RATE] = add_mod(r_lane[RATE], w_count);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm       <= ST_ABSORB;
      r_lane      <= '0;
      r_perm_o    <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_final     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_fsm)
        ST_ABSORB: begin
          if (w_hs) begin
            r_lane <= w_upd;
            if (w_blk_done) begin
              r_perm_o <= w_upd;
              r_cnt    <= CNT_W'(1);
              r_final  <= bus.in_last;
              r_fsm    <= ST_PERM;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_PERM: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Only the core output on the capture edge belongs to this launch
          if (w_capture) begin
            r_lane <= perm_state_i;
            r_idx  <= '0;
            if (r_final) begin
              r_out_data  <= perm_state_i[DIGEST*31-1:0];
              r_out_valid <= 1'b1;
              r_fsm       <= ST_OUTPUT;
            end else begin
              r_fsm <= ST_ABSORB;
            end
          end
        end
        ST_OUTPUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_lane      <= '0;
            r_final     <= 1'b0;
            r_fsm       <= ST_ABSORB;
          end
        end
        default: r_fsm <= ST_ABSORB;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign perm_state_o  = r_perm_o;
  assign busy          = (r_fsm == ST_PERM) || (r_fsm == ST_OUTPUT);

endmodule
